// File: rtl/rom_angulos_sweep.sv
// Angle ROM with a timed address sweep: single-pass, wrapping or ping-pong.
// Every output is registered; saida follows endereco with no extra latency.
module rom_angulos_sweep #(
  parameter int unsigned          N_ENDERECOS  = 8,
  parameter int unsigned          LARGURA      = 24,
  parameter int unsigned          DWELL_CICLOS = 4,
  parameter logic [LARGURA-1:0]   VALOR_BASE   = LARGURA'(24'h000010),
  parameter logic [LARGURA-1:0]   PASSO        = LARGURA'(24'h000010)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           iniciar,
  input  logic                           parar,
  input  logic [1:0]                     modo,
  output logic [$clog2(N_ENDERECOS)-1:0] endereco,
  output logic [LARGURA-1:0]             saida,
  output logic                           valido,
  output logic                           ocupado,
  output logic                           fim
);

  localparam int unsigned AW = $clog2(N_ENDERECOS);
  localparam int unsigned CW = (DWELL_CICLOS > 1) ? $clog2(DWELL_CICLOS) : 1;
  localparam logic [AW-1:0] ULTIMO  = AW'(N_ENDERECOS - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DWELL_CICLOS - 1);

  localparam logic [1:0] MODO_UNICO = 2'b00;
  localparam logic [1:0] MODO_CONT  = 2'b01;
  localparam logic [1:0] MODO_PING  = 2'b10;

  typedef enum logic [1:0] {OCIOSO, VARRE, FIM} estado_t;

  logic [LARGURA-1:0] tabela_angulos [N_ENDERECOS];

  for (genvar i = 0; i < N_ENDERECOS; i++) begin : g_tabela
    assign tabela_angulos[i] = VALOR_BASE + LARGURA'(i) * PASSO;
  end

  estado_t            estado_q, estado_d;
  logic [AW-1:0]      endereco_q, endereco_d;
  logic [LARGURA-1:0] saida_q, saida_d;
  logic               valido_q, valido_d;
  logic               ocupado_q, ocupado_d;
  logic               fim_q, fim_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         modo_q, modo_d;
  logic               desce_q, desce_d;
  logic               carrega;
  logic               volta;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q   <= OCIOSO;
      endereco_q <= '0;
      saida_q    <= '0;
      valido_q   <= 1'b0;
      ocupado_q  <= 1'b0;
      fim_q      <= 1'b0;
      cnt_q      <= '0;
      modo_q     <= MODO_UNICO;
      desce_q    <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      endereco_q <= endereco_d;
      saida_q    <= saida_d;
      valido_q   <= valido_d;
      ocupado_q  <= ocupado_d;
      fim_q      <= fim_d;
      cnt_q      <= cnt_d;
      modo_q     <= modo_d;
      desce_q    <= desce_d;
    end
  end

  always_comb begin
    estado_d   = estado_q;
    endereco_d = endereco_q;
    saida_d    = saida_q;
    valido_d   = valido_q;
    ocupado_d  = ocupado_q;
    fim_d      = 1'b0;
    cnt_d      = cnt_q;
    modo_d     = modo_q;
    desce_d    = desce_q;
    carrega    = 1'b0;
    volta      = desce_q || (endereco_q == ULTIMO);

    unique case (estado_q)
      OCIOSO: begin
        ocupado_d = 1'b0;
        if (iniciar && !parar) begin
          estado_d   = VARRE;
          endereco_d = '0;
          cnt_d      = '0;
          ocupado_d  = 1'b1;
          valido_d   = 1'b1;
          modo_d     = (modo == 2'b11) ? MODO_UNICO : modo;
          desce_d    = 1'b0;
          carrega    = 1'b1;
        end
      end
      VARRE: begin
        if (parar) begin
          estado_d  = OCIOSO;
          ocupado_d = 1'b0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = '0;
          case (modo_q)
            MODO_CONT: begin
              endereco_d = (endereco_q == ULTIMO) ? '0 : endereco_q + AW'(1);
              fim_d      = (endereco_d == '0);
              carrega    = 1'b1;
            end
            MODO_PING: begin
              // Turn around at the top; reaching 0 completes a cycle and re-arms upward.
              endereco_d = volta ? endereco_q - AW'(1) : endereco_q + AW'(1);
              desce_d    = volta && (endereco_d != '0);
              fim_d      = (endereco_d == '0);
              carrega    = 1'b1;
            end
            default: begin
              if (endereco_q == ULTIMO) begin
                estado_d  = FIM;
                fim_d     = 1'b1;
                ocupado_d = 1'b0;
              end else begin
                endereco_d = endereco_q + AW'(1);
                carrega    = 1'b1;
              end
            end
          endcase
        end
      end
      FIM: begin
        estado_d  = OCIOSO;
        ocupado_d = 1'b0;
      end
      default: begin
        estado_d  = OCIOSO;
        ocupado_d = 1'b0;
      end
    endcase

    if (carrega) saida_d = tabela_angulos[endereco_d];
  end

  assign endereco = endereco_q;
  assign saida    = saida_q;
  assign valido   = valido_q;
  assign ocupado  = ocupado_q;
  assign fim      = fim_q;

endmodule

// File: doc/rom_angulos_sweep.md
ROM_ANGULOS_SWEEP -- requirements
Module: rom_angulos_sweep

Interface
REQ-001 Parameter N_ENDERECOS, default 8, ROM depth; SHALL be >= 2.
REQ-002 Parameter LARGURA, default 24, ROM word width in bits.
REQ-003 Parameter DWELL_CICLOS, default 4, clock cycles each address is held during a sweep; SHALL be >= 1.
REQ-004 Parameter VALOR_BASE, default 24'h000010, content of entry 0.
REQ-005 Parameter PASSO, default 24'h000010, increment between consecutive entries.
REQ-006 clock  input  1  single rising-edge clock for all state.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 iniciar  input  1  start pulse, sampled on clock edge.
REQ-009 parar  input  1  stop request, sampled on clock edge.
REQ-010 modo  input  2  sweep mode: 00 single up, 01 continuous wrap, 10 ping-pong, 11 treated as 00.
REQ-011 endereco  output  $clog2(N_ENDERECOS)  current ROM address.
REQ-012 saida  output  LARGURA  registered ROM word for endereco.
REQ-013 valido  output  1  high while saida reflects a sweep-addressed entry.
REQ-014 ocupado  output  1  high while a sweep is running.
REQ-015 fim  output  1  one-cycle completion pulse.

Function
REQ-016 ROM entry i SHALL equal (VALOR_BASE + i*PASSO) mod 2^LARGURA, fixed at elaboration; internal array SHALL be named tabela_angulos.
REQ-017 saida SHALL equal tabela_angulos[endereco], updated in the same edge that updates endereco (no extra latency visible at the ports).
REQ-018 FSM states: OCIOSO, VARRE, FIM.
REQ-019 OCIOSO: on iniciar=1 and parar=0 -> VARRE next edge; endereco=0, dwell counter=0, ocupado=1, valido=1, modo latched.
REQ-020 VARRE: dwell counter increments each cycle; when it reaches DWELL_CICLOS-1, next edge advances address and clears counter; each address thus held exactly DWELL_CICLOS cycles.
REQ-021 Mode 00: after last address (N_ENDERECOS-1) completes its dwell -> FIM; endereco/saida hold last entry.
REQ-022 Mode 01: after N_ENDERECOS-1 wraps to 0; fim pulses for one cycle coincident with the wrap edge; runs until parar.
REQ-023 Mode 10: direction up until N_ENDERECOS-1, then down to 0; endpoints not repeated; fim pulses on the edge endereco returns to 0; runs until parar.
REQ-024 FIM: fim=1 and ocupado=0 for exactly one cycle, then OCIOSO; valido stays 1.
REQ-025 parar=1 in VARRE -> OCIOSO next edge, endereco/saida held, ocupado=0, no fim pulse.
REQ-026 parar and iniciar both 1 in same cycle: parar wins; no sweep starts.
REQ-027 iniciar while ocupado=1 SHALL be ignored; modo changes while ocupado=1 SHALL be ignored.
REQ-028 iniciar in FIM cycle ignored; accepted from OCIOSO onward.

Reset
REQ-029 reset=0 asynchronously forces OCIOSO, endereco=0, saida=0, dwell counter=0, valido=0, ocupado=0, fim=0, direction=up, latched modo=00.
REQ-030 Reset asserted mid-sweep SHALL abort without fim; after release block waits in OCIOSO for iniciar.

Verification (N=8, LARGURA=24, DWELL=4, BASE=PASSO=24'h000010)
REQ-031 Reset release, no iniciar -> endereco=0, saida=0, valido=0, ocupado=0 for 20 cycles.
REQ-032 modo=00, iniciar pulse -> endereco 0..7 each held 4 cycles, saida=24'h000010*(endereco+1), fim single pulse after 32 cycles, final saida=24'h000080.
REQ-033 modo=01 -> after 7 goes to 0, fim pulse at each wrap (every 32 cycles); parar at endereco=3 -> OCIOSO, saida holds 24'h000040.
REQ-034 modo=10 -> address sequence 0..7,6..0 each held 4 cycles, fim pulse when 0 reached (after 56 cycles), continues upward.
REQ-035 iniciar and parar simultaneous in OCIOSO -> ocupado stays 0; iniciar mid-sweep -> sequence unaffected.
REQ-036 reset=0 at endereco=5 asynchronously -> all outputs to reset values within same cycle, fim never pulses.
